// File: rtl/easyaxi_rd_sched_if.sv
// AXI read-address and read-data channel bundle between the scheduler (master)
// and the EASYAXI master core / interconnect (slave).
interface easyaxi_rd_sched_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [ID_W-1:0]   arid;
  logic              rvalid;
  logic              rready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output arvalid, araddr, arlen, arid, rready,
    input  arready, rvalid, rid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, arid, rready,
    output arready, rvalid, rid, rdata, rresp, rlast
  );
endinterface

// File: rtl/easyaxi_rd_sched.sv
// Round-robin read scheduler: REQ_NUM requesters share one AR channel, ARID is the
// requester index, R beats are steered back by RID with per-requester outstanding limits.
module easyaxi_rd_sched #(
  parameter int REQ_NUM  = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ID_W     = 4,
  parameter int OUTS_MAX = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [REQ_NUM-1:0]        req_valid,
  output logic [REQ_NUM-1:0]        req_ready,
  input  logic [REQ_NUM*ADDR_W-1:0] req_addr,
  input  logic [REQ_NUM*8-1:0]      req_len,
  easyaxi_rd_sched_if.master        axi,
  output logic [REQ_NUM-1:0]        rsp_valid,
  input  logic [REQ_NUM-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [1:0]                rsp_resp,
  output logic                      rsp_last,
  output logic                      rd_resp_err
);
  localparam int OW = $clog2(OUTS_MAX + 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                    state;
  logic [REQ_NUM-1:0][OW-1:0] outs;
  logic [ID_W-1:0]           last_grant;
  logic [REQ_NUM-1:0]        elig, inc_v, dec_v;
  logic [ID_W-1:0]           win;
  logic                      win_ok, grant;
  logic [ADDR_W-1:0]         win_addr;
  logic [7:0]                win_len;
  logic                      rid_ok, ar_hs, r_hs, r_last_hs, underflow;
  int                        idx;

  // Rotating priority: search starts one past the last granted requester.
  always_comb begin
    idx      = 0;
    win      = '0;
    win_ok   = 1'b0;
    win_addr = '0;
    win_len  = '0;
    for (int i = 0; i < REQ_NUM; i++)
      elig[i] = req_valid[i] && (outs[i] < OW'(OUTS_MAX));
    for (int k = 1; k <= REQ_NUM; k++) begin
      idx = (int'(last_grant) + k) % REQ_NUM;
      for (int i = 0; i < REQ_NUM; i++)
        if (!win_ok && i == idx && elig[i]) begin
          win_ok = 1'b1;
          win    = ID_W'(i);
        end
    end
    for (int i = 0; i < REQ_NUM; i++)
      if (win == ID_W'(i)) begin
        win_addr = req_addr[i*ADDR_W +: ADDR_W];
        win_len  = req_len[i*8 +: 8];
      end
  end

  assign grant = (state == IDLE) && enable && win_ok && !rst;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < REQ_NUM; i++)
      req_ready[i] = grant && (win == ID_W'(i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      axi.arvalid <= 1'b0;
      axi.araddr  <= '0;
      axi.arlen   <= '0;
      axi.arid    <= '0;
      last_grant  <= ID_W'(REQ_NUM - 1);
    end else begin
      case (state)
        IDLE: if (grant) begin
          axi.arvalid <= 1'b1;
          axi.araddr  <= win_addr;
          axi.arlen   <= win_len;
          axi.arid    <= win;
          state       <= ISSUE;
        end
        ISSUE: if (axi.arready) begin
          axi.arvalid <= 1'b0;
          last_grant  <= axi.arid;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // R steering is purely combinational; unknown IDs are swallowed so the bus never stalls.
  assign rid_ok = int'(axi.rid) < REQ_NUM;

  always_comb begin
    rsp_valid  = '0;
    axi.rready = 1'b1;
    if (rid_ok) begin
      axi.rready = 1'b0;
      for (int i = 0; i < REQ_NUM; i++)
        if (axi.rid == ID_W'(i)) begin
          rsp_valid[i] = axi.rvalid;
          axi.rready   = rsp_ready[i];
        end
    end
  end

  assign rsp_data  = axi.rdata;
  assign rsp_resp  = axi.rresp;
  assign rsp_last  = axi.rlast;
  assign ar_hs     = axi.arvalid && axi.arready;
  assign r_hs      = axi.rvalid && axi.rready;
  assign r_last_hs = r_hs && axi.rlast && rid_ok;

  always_comb begin
    underflow = 1'b0;
    for (int i = 0; i < REQ_NUM; i++) begin
      inc_v[i] = ar_hs && (axi.arid == ID_W'(i));
      dec_v[i] = r_last_hs && (axi.rid == ID_W'(i));
      if (dec_v[i] && !inc_v[i] && outs[i] == '0) underflow = 1'b1;
    end
  end

  // A simultaneous issue and completion on one ID leaves its count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outs <= '0;
    end else begin
      for (int i = 0; i < REQ_NUM; i++) begin
        if (inc_v[i] && !dec_v[i])
          outs[i] <= outs[i] + OW'(1);
        else if (dec_v[i] && !inc_v[i] && outs[i] != '0)
          outs[i] <= outs[i] - OW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rd_resp_err <= 1'b0;
    else if ((axi.rvalid && !rid_ok) || (r_hs && axi.rresp != 2'b00) || underflow)
      rd_resp_err <= 1'b1;
  end
endmodule

// File: tb/tb_easyaxi_rd_sched.sv
// Scoreboard bench for easyaxi_rd_sched: a reference arbiter/counter model predicts
// every grant, AR beat, R routing decision and the sticky error flag.
module tb_easyaxi_rd_sched;
  localparam int REQ_NUM = 2, ADDR_W = 32, DATA_W = 32, ID_W = 4, OUTS_MAX = 4;

  logic        clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic [1:0]  req_valid = '0, req_ready, rsp_valid, rsp_ready = 2'b11;
  logic [63:0] req_addr = '0;
  logic [15:0] req_len = '0;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic        rsp_last, rd_resp_err;

  always #5 clk = ~clk;

  easyaxi_rd_sched_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) axi();

  easyaxi_rd_sched #(.REQ_NUM(REQ_NUM), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                     .ID_W(ID_W), .OUTS_MAX(OUTS_MAX)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .axi(axi),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_last(rsp_last),
    .rd_resp_err(rd_resp_err)
  );

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  ar_t         ar_q[$];
  logic [31:0] r_q0[$], r_q1[$];
  logic        pending_m = 1'b0, err_m = 1'b0;
  int          outs_m[2];
  int          last_m = 1;
  int          ar_cnt = 0, gnt_cnt = 0;

  function automatic logic [1:0] pick();
    int i;
    logic [1:0] oh;
    for (int k = 1; k <= 2; k++) begin
      i = (last_m + k) % 2;
      if (req_valid[i] && outs_m[i] < OUTS_MAX) begin
        oh = 2'b01 << i;
        return oh;
      end
    end
    return 2'b00;
  endfunction

  always @(negedge clk) begin
    logic [1:0]  eg, oh;
    ar_t         e;
    int          id;
    logic [31:0] d;
    if (rst) begin
      pending_m = 1'b0;
      err_m     = 1'b0;
      outs_m[0] = 0;
      outs_m[1] = 0;
      last_m    = 1;
      ar_q.delete();
    end else begin
      eg = 2'b00;
      if (!pending_m && enable) eg = pick();
      chk("req_ready", req_ready, eg);
      chk("arvalid", axi.arvalid, pending_m);
      chk("rd_resp_err", rd_resp_err, err_m);
      if (req_ready != 2'b00) gnt_cnt++;
      if (axi.arvalid) begin
        chk("ar_q_nonempty", ar_q.size() > 0, 1);
        if (ar_q.size() > 0) begin
          chk("arid", axi.arid, ar_q[0].id);
          chk("araddr", axi.araddr, ar_q[0].addr);
          chk("arlen", axi.arlen, ar_q[0].len);
          if (axi.arready) begin
            e = ar_q.pop_front();
            outs_m[e.id]++;
            last_m    = e.id;
            pending_m = 1'b0;
            ar_cnt++;
          end
        end
      end
      if (eg != 2'b00) begin
        e.id   = eg[1] ? 4'd1 : 4'd0;
        e.addr = eg[1] ? req_addr[63:32] : req_addr[31:0];
        e.len  = eg[1] ? req_len[15:8] : req_len[7:0];
        ar_q.push_back(e);
        pending_m = 1'b1;
      end
      if (axi.rvalid) begin
        chk("rsp_pass", {rsp_data, rsp_resp, rsp_last}, {axi.rdata, axi.rresp, axi.rlast});
        if (axi.rid < 2) begin
          id = int'(axi.rid);
          oh = 2'b01 << id;
          chk("rsp_valid", rsp_valid, oh);
          chk("rready", axi.rready, rsp_ready[id]);
          if (axi.rready) begin
            d = (id == 0) ? r_q0.pop_front() : r_q1.pop_front();
            chk("rsp_data", rsp_data, d);
            if (axi.rlast) begin
              if (outs_m[id] == 0) err_m = 1'b1;
              else outs_m[id]--;
            end
          end
        end else begin
          chk("rsp_valid_bad_id", rsp_valid, 2'b00);
          chk("rready_bad_id", axi.rready, 1'b1);
          err_m = 1'b1;
        end
        if (axi.rready && axi.rresp != 2'b00) err_m = 1'b1;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ar(input int target);
    for (int c = 0; c < 60 && ar_cnt < target; c++) cyc(1);
    chk("ar_wait", ar_cnt, target);
  endtask

  task automatic r_beat(input logic [3:0] id, input logic [31:0] d, input logic [1:0] resp,
                        input logic last, input logic tog);
    logic hs;
    hs = 1'b0;
    if (id == 4'd0) r_q0.push_back(d);
    else if (id == 4'd1) r_q1.push_back(d);
    axi.rvalid = 1'b1;
    axi.rid    = id;
    axi.rdata  = d;
    axi.rresp  = resp;
    axi.rlast  = last;
    for (int c = 0; c < 40 && !hs; c++) begin
      @(negedge clk);
      hs = axi.rready;
      @(posedge clk);
      #1;
      if (tog) rsp_ready[1] = ~rsp_ready[1];
    end
    chk("r_handshake", hs, 1'b1);
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
  endtask

  initial begin
    int base, g;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rid     = '0;
    axi.rdata   = '0;
    axi.rresp   = '0;
    axi.rlast   = 1'b0;
    req_addr    = {32'h2000_0004, 32'h1000_0000};
    req_len     = {8'd7, 8'd3};

    // Reset with requests already pending: nothing may leak out while rst is high.
    req_valid   = 2'b11;
    enable      = 1'b1;
    axi.arready = 1'b1;
    cyc(2);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_arvalid", axi.arvalid, 1'b0);
    chk("rst_ar_fields", {axi.araddr, axi.arlen, axi.arid}, 44'd0);
    chk("rst_err", rd_resp_err, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Both requesters held: grants alternate 0,1,0,1 back-to-back.
    wait_ar(4);
    req_valid = 2'b00;
    cyc(2);
    r_beat(0, 32'hA000_0001, 2'b00, 1'b1, 1'b0);
    r_beat(0, 32'hA000_0002, 2'b00, 1'b1, 1'b0);
    r_beat(1, 32'hB000_0001, 2'b00, 1'b1, 1'b0);
    r_beat(1, 32'hB000_0002, 2'b00, 1'b1, 1'b0);

    // Outstanding limit on requester 0, released by one completion.
    req_addr[31:0] = 32'h1000_0100;
    req_valid = 2'b01;
    base = ar_cnt;
    cyc(14);
    chk("limit_4", ar_cnt - base, 4);
    r_beat(0, 32'hC000_0000, 2'b00, 1'b1, 1'b0);
    cyc(3);
    chk("limit_5th", ar_cnt - base, 5);
    req_valid = 2'b00;
    for (int k = 0; k < 4; k++) r_beat(0, 32'hC000_0010 + k, 2'b00, 1'b1, 1'b0);

    // AR stalled: fields held, a single grant only.
    axi.arready = 1'b0;
    req_addr[63:32] = 32'h2000_0ABC;
    req_len[15:8]   = 8'd3;
    req_valid = 2'b10;
    g = gnt_cnt;
    cyc(6);
    chk("stall_one_grant", gnt_cnt - g, 1);
    axi.arready = 1'b1;
    req_valid   = 2'b00;
    cyc(2);

    // Four-beat burst to requester 1 with a toggling consumer.
    rsp_ready = 2'b01;
    for (int k = 0; k < 4; k++) r_beat(1, 32'hD000_0000 + k, 2'b00, k == 3, 1'b1);
    rsp_ready = 2'b11;
    cyc(2);

    // enable dropped while an AR is waiting.
    axi.arready = 1'b0;
    req_valid   = 2'b01;
    cyc(1);
    enable = 1'b0;
    cyc(2);
    g    = gnt_cnt;
    base = ar_cnt;
    axi.arready = 1'b1;
    cyc(5);
    chk("en_ar_done", ar_cnt - base, 1);
    chk("en_no_grant", gnt_cnt - g, 0);
    req_valid = 2'b00;
    enable    = 1'b1;
    r_beat(0, 32'hE000_0000, 2'b00, 1'b1, 1'b0);
    cyc(2);
    chk("err_clean", rd_resp_err, 1'b0);

    // Error sources: SLVERR beat, unknown ID, counter underflow; each sticky until rst.
    r_beat(0, 32'hF000_0001, 2'b10, 1'b0, 1'b0);
    cyc(3);
    chk("err_resp_sticky", rd_resp_err, 1'b1);
    rst = 1'b1;
    cyc(1);
    chk("err_rst_clr", rd_resp_err, 1'b0);
    rst = 1'b0;
    cyc(1);
    r_beat(7, 32'hF000_0007, 2'b00, 1'b1, 1'b0);
    cyc(2);
    chk("err_bad_id", rd_resp_err, 1'b1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    r_beat(1, 32'hF000_0011, 2'b00, 1'b1, 1'b0);
    cyc(2);
    chk("err_underflow", rd_resp_err, 1'b1);
    rst = 1'b1;
    cyc(2);
    chk("err_final_clr", rd_resp_err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
